// File: rtl/risc16bp_if.sv
// Instruction and data memory bus for the risc16bp core.
// The core drives it through the master modport; the memories use the slave modport.
interface risc16bp_if;
   logic [15:0] iaddr;
   logic        ioe;
   logic [15:0] idin;
   logic        iready;
   logic [15:0] daddr;
   logic [15:0] ddout;
   logic        doe;
   logic        dwe0;
   logic        dwe1;
   logic [15:0] ddin;
   logic        dready;

   modport master (
      output iaddr, ioe, daddr, ddout, doe, dwe0, dwe1,
      input  idin, iready, ddin, dready
   );

   modport slave (
      input  iaddr, ioe, daddr, ddout, doe, dwe0, dwe1,
      output idin, iready, ddin, dready
   );
endinterface

// File: rtl/risc16bp.sv
// RISC16 3-stage (IF/RF/EX) core with branch prediction, misprediction flush,
// memory ready handshakes and RF-stage forwarding. Define RISC16BP_BPT_EN to build the BPT.
module risc16bp #(
   parameter int unsigned BPT_ENTRIES = 16,
   parameter logic [15:0] RESET_PC    = 16'h0000
) (
   input  logic       clk,
   input  logic       rst,
   risc16bp_if.master bus
);
   localparam logic [15:0] NOP = 16'h0000;

   logic [15:0] regs [8];
   logic [15:0] pc_if;
   logic        ioe_q;
   logic [15:0] ir_rf, pc_rf, pn_rf;
   logic        v_rf;
   logic [15:0] ir_ex, pc_ex, pn_ex, a_ex, b_ex;
   logic        v_ex;

   logic [2:0]  rd_ex, rd_rf, rs_rf;
   logic [4:0]  func_ex;
   logic [3:0]  op_ex;
   logic        is_rg, is_imm, is_br, is_jmp, is_st, is_ld, is_sbu, is_lbu, is_mem;
   logic        cond, taken, wr_en, stall, mispredict;
   logic [15:0] alu_b, alu_y, res_ex, seq_ex, tgt_ex, next_ex;
   logic [15:0] fwd_a, fwd_b, pred_next;

   function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] a,
                                       input logic [15:0] b);
      logic [15:0] y;
      case (op)
         4'h0:    y = a;
         4'h1:    y = b;
         4'h2:    y = ~b;
         4'h3:    y = a ^ b;
         4'h4:    y = a + b;
         4'h5:    y = a - b;
         4'h6:    y = {b[7:0], 8'h00};
         4'h8:    y = {b[14:0], 1'b0};
         4'h9:    y = {1'b0, b[15:1]};
         4'hA:    y = a & b;
         4'hB:    y = a | b;
         default: y = 16'h0000;
      endcase
      return y;
   endfunction

   // EX decode, execute, branch resolution
   always_comb begin
      rd_ex   = ir_ex[10:8];
      func_ex = ir_ex[4:0];
      is_rg   = (ir_ex[15:11] == 5'b00000);
      is_imm  = ~ir_ex[15] & (ir_ex[14:11] != 4'h0);
      is_br   = (ir_ex[15:14] == 2'b10);
      is_jmp  = (ir_ex[15:14] == 2'b11);
      is_st   = is_rg & (func_ex == 5'b10000);
      is_ld   = is_rg & (func_ex == 5'b10001);
      is_sbu  = is_rg & (func_ex == 5'b10010);
      is_lbu  = is_rg & (func_ex == 5'b10011);
      is_mem  = v_ex & (is_st | is_ld | is_sbu | is_lbu);
      op_ex   = is_rg ? ir_ex[3:0] : ir_ex[14:11];
      if (is_rg)               alu_b = b_ex;
      else if (op_ex == 4'h4)  alu_b = {{8{ir_ex[7]}}, ir_ex[7:0]};
      else                     alu_b = {8'h00, ir_ex[7:0]};
      alu_y = alu(op_ex, a_ex, alu_b);
      if (is_ld)        res_ex = bus.ddin;
      else if (is_lbu)  res_ex = b_ex[0] ? {8'h00, bus.ddin[7:0]} : {8'h00, bus.ddin[15:8]};
      else              res_ex = alu_y;
      wr_en  = v_ex & ((is_rg & ~func_ex[4] & (ir_ex != NOP)) | is_imm | is_ld | is_lbu);
      stall  = is_mem & ~bus.dready;
      seq_ex = pc_ex + 16'd2;
      tgt_ex = is_jmp ? seq_ex + {{5{ir_ex[10]}}, ir_ex[10:0]}
                      : seq_ex + {{8{ir_ex[7]}}, ir_ex[7:0]};
      cond = 1'b0;
      case (ir_ex[12:11])
         2'b00: cond = (a_ex != 16'h0000);
         2'b01: cond = (a_ex == 16'h0000);
         2'b10: cond = a_ex[15];
         2'b11: cond = ~a_ex[15];
         default: cond = 1'b0;
      endcase
      taken      = (is_br & cond) | is_jmp;
      next_ex    = taken ? tgt_ex : seq_ex;
      mispredict = v_ex & (next_ex != pn_ex);
   end

   // Data memory strobes follow the instruction sitting in EX
   always_comb begin
      bus.daddr = 16'h0000;
      bus.ddout = 16'h0000;
      bus.doe   = 1'b0;
      bus.dwe0  = 1'b0;
      bus.dwe1  = 1'b0;
      if (is_mem) begin
         bus.daddr = b_ex;
         if (is_st) begin
            bus.ddout = a_ex;
            bus.dwe0  = 1'b1;
            bus.dwe1  = 1'b1;
         end else if (is_sbu) begin
            bus.ddout = {a_ex[7:0], a_ex[7:0]};
            bus.dwe0  = b_ex[0];
            bus.dwe1  = ~b_ex[0];
         end else begin
            bus.doe = 1'b1;
         end
      end
   end

   // RF operand read with bypass from the EX result (loads included)
   always_comb begin
      rd_rf = ir_rf[10:8];
      rs_rf = ir_rf[7:5];
      fwd_a = (wr_en && (rd_ex == rd_rf)) ? res_ex : regs[rd_rf];
      fwd_b = (wr_en && (rd_ex == rs_rf)) ? res_ex : regs[rs_rf];
   end

`ifdef RISC16BP_BPT_EN
   localparam int unsigned IDX_W = $clog2(BPT_ENTRIES);
   localparam int unsigned TAG_W = 15 - IDX_W;

   logic             bpt_v   [BPT_ENTRIES];
   logic [TAG_W-1:0] bpt_tag [BPT_ENTRIES];
   logic [15:0]      bpt_tgt [BPT_ENTRIES];
   logic [1:0]       bpt_ctr [BPT_ENTRIES];
   logic [IDX_W-1:0] idx_if, idx_ex;
   logic             hit_if, hit_ex;

   always_comb begin
      idx_if    = pc_if[IDX_W:1];
      idx_ex    = pc_ex[IDX_W:1];
      hit_if    = bpt_v[idx_if] && (bpt_tag[idx_if] == pc_if[15:IDX_W+1]);
      hit_ex    = bpt_v[idx_ex] && (bpt_tag[idx_ex] == pc_ex[15:IDX_W+1]);
      pred_next = (hit_if && bpt_ctr[idx_if][1]) ? bpt_tgt[idx_if] : pc_if + 16'd2;
   end

   // BPT training on resolved branches and jumps
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(BPT_ENTRIES); i++) bpt_v[i] <= 1'b0;
      end else if (v_ex && (is_br || is_jmp) && !stall) begin
         if (taken) begin
            bpt_tgt[idx_ex] <= tgt_ex;
            if (hit_ex) begin
               if (bpt_ctr[idx_ex] != 2'd3) bpt_ctr[idx_ex] <= bpt_ctr[idx_ex] + 2'd1;
            end else begin
               bpt_v[idx_ex]   <= 1'b1;
               bpt_tag[idx_ex] <= pc_ex[15:IDX_W+1];
               bpt_ctr[idx_ex] <= 2'd2;
            end
         end else if (hit_ex && (bpt_ctr[idx_ex] != 2'd0)) begin
            bpt_ctr[idx_ex] <= bpt_ctr[idx_ex] - 2'd1;
         end
      end
   end
`else
   logic [8:0] unused_bpt_cfg;
   assign unused_bpt_cfg = 9'(BPT_ENTRIES);

   always_comb pred_next = pc_if + 16'd2;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
      end else if (wr_en && !stall) begin
         regs[rd_ex] <= res_ex;
      end
   end

   // Pipeline advance; a redirect overrides fetch, a data stall freezes everything
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_if <= RESET_PC;
         ioe_q <= 1'b1;
         ir_rf <= NOP;
         pc_rf <= 16'h0000;
         pn_rf <= 16'h0000;
         v_rf  <= 1'b0;
         ir_ex <= NOP;
         pc_ex <= 16'h0000;
         pn_ex <= 16'h0000;
         a_ex  <= 16'h0000;
         b_ex  <= 16'h0000;
         v_ex  <= 1'b0;
      end else if (!stall) begin
         ioe_q <= 1'b1;
         v_ex  <= v_rf & ~mispredict;
         ir_ex <= mispredict ? NOP : ir_rf;
         pc_ex <= pc_rf;
         pn_ex <= pn_rf;
         a_ex  <= fwd_a;
         b_ex  <= fwd_b;
         if (mispredict) begin
            pc_if <= next_ex;
            ir_rf <= NOP;
            v_rf  <= 1'b0;
         end else if (bus.iready) begin
            pc_if <= pred_next;
            ir_rf <= bus.idin;
            pc_rf <= pc_if;
            pn_rf <= pred_next;
            v_rf  <= 1'b1;
         end else begin
            ir_rf <= NOP;
            v_rf  <= 1'b0;
         end
      end
   end

   assign bus.iaddr = pc_if;
   assign bus.ioe   = ioe_q;
endmodule

// File: tb/tb_risc16bp.sv
// Self-checking bench for risc16bp: a directed program whose stores are scoreboarded,
// plus timing checks on the branch loop, a data stall, a fetch stall and reset mid-stall.
module tb_risc16bp;
   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   st_cyc [16];
   bit   st_done = 0;
   bit   ir_done = 0;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] d;
      logic        w0;
      logic        w1;
   } st_t;
   st_t sb[$];

   logic [15:0] imem [128];
   logic [15:0] dmem [256];

   risc16bp_if bus();

   risc16bp #(.BPT_ENTRIES(16), .RESET_PC(16'h0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   localparam int PASSB = 1, NOTB = 2, XORO = 3, ADDO = 4, SUBO = 5, SHL8 = 6, ZERO7 = 7;
   localparam int SHL1 = 8, SHR1 = 9, ANDO = 10, ORO = 11;
   localparam int F_ST = 16, F_LD = 17, F_SBU = 18, F_LBU = 19;

   function automatic logic [15:0] rg(input int rd, input int rs, input int func);
      return {5'b00000, 3'(rd), 3'(rs), 5'(func)};
   endfunction
   function automatic logic [15:0] im(input int op, input int rd, input int imm);
      return {1'b0, 4'(op), 3'(rd), 8'(imm)};
   endfunction
   function automatic logic [15:0] br(input int c, input int rd, input int off);
      return {2'b10, 1'b0, 2'(c), 3'(rd), 8'(off)};
   endfunction
   function automatic logic [15:0] jp(input int off);
      return {2'b11, 3'b000, 11'(off)};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] a, input logic [15:0] d, input logic w0, input logic w1);
      st_t e;
      e.a = a; e.d = d; e.w0 = w0; e.w1 = w1;
      sb.push_back(e);
   endtask

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   assign bus.idin = imem[bus.iaddr[7:1]];
   assign bus.ddin = dmem[bus.daddr[8:1]];

   // Byte-lane data memory
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) dmem[i] <= 16'h0000;
         dmem[8] <= 16'hA55A;
      end else if (bus.dready) begin
         if (bus.dwe0) dmem[bus.daddr[8:1]][7:0]  <= bus.ddout[7:0];
         if (bus.dwe1) dmem[bus.daddr[8:1]][15:8] <= bus.ddout[15:8];
      end
   end

   // Store monitor: every completing write is popped against the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && bus.dready && (bus.dwe0 || bus.dwe1)) begin
            if (bus.daddr >= 16'h0100 && bus.daddr < 16'h0120) st_cyc[bus.daddr[4:1]] = cyc;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_store addr=%h data=%h", bus.daddr, bus.ddout);
            end else begin
               st_t e;
               logic [15:0] m;
               e = sb.pop_front();
               m = {{8{e.w1}}, {8{e.w0}}};
               check("st_addr", bus.daddr, e.a);
               check("st_lanes", {14'b0, bus.dwe1, bus.dwe0}, {14'b0, e.w1, e.w0});
               check("st_data", bus.ddout & m, e.d & m);
            end
         end
      end
   end

   // Data-ready driver: 3-cycle stall on the 0x112 store, open-ended stall on 0x118
   initial begin
      bus.dready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (!rst && bus.dwe0 && bus.dwe1 && bus.daddr == 16'h0112 && !st_done) begin
            st_done = 1;
            bus.dready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("stall_daddr", bus.daddr, 16'h0112);
               check("stall_ddout", bus.ddout, 16'h001E);
               check("stall_iaddr", bus.iaddr, 16'd100);
               @(posedge clk);
            end
            #1 bus.dready = 1'b1;
         end else if (!rst && bus.dwe0 && bus.daddr == 16'h0118) begin
            bus.dready = 1'b0;
            wait (rst);
            #1 bus.dready = 1'b1;
         end
      end
   end

   // Instruction-ready driver: two fetch bubbles when fetch reaches 102
   initial begin
      bus.iready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (!rst && bus.iaddr == 16'd102 && !ir_done) begin
            ir_done = 1;
            bus.iready = 1'b0;
            repeat (2) @(posedge clk);
            #1 bus.iready = 1'b1;
         end
      end
   end

   initial begin
      bit found;
      int gap_exp;
      rst = 1'b1;
      for (int i = 0; i < 16; i++) st_cyc[i] = 0;
      for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
      imem[0]  = im(ADDO, 1, 5);    imem[1]  = im(ADDO, 1, -1);   imem[2]  = rg(2, 1, ADDO);
      imem[3]  = im(PASSB, 7, 1);   imem[4]  = im(SHL8, 7, 1);    imem[5]  = rg(1, 7, F_ST);
      imem[6]  = im(ADDO, 7, 2);    imem[7]  = rg(2, 7, F_ST);
      imem[8]  = im(PASSB, 3, 16);  imem[9]  = rg(4, 3, F_LD);    imem[10] = rg(5, 4, ADDO);
      imem[11] = im(ADDO, 7, 2);    imem[12] = rg(5, 7, F_ST);    imem[13] = rg(4, 3, F_LBU);
      imem[14] = im(ADDO, 7, 2);    imem[15] = rg(4, 7, F_ST);
      imem[16] = im(PASSB, 6, 8'h12); imem[17] = im(SHL8, 6, 8'h12); imem[18] = im(ORO, 6, 8'h34);
      imem[19] = im(PASSB, 0, 8'h21); imem[20] = rg(6, 0, F_SBU); imem[21] = im(PASSB, 0, 8'h20);
      imem[22] = rg(6, 0, F_SBU);   imem[23] = rg(5, 0, F_LD);    imem[24] = im(ADDO, 7, 2);
      imem[25] = rg(5, 7, F_ST);
      imem[26] = im(PASSB, 1, 8'hF0); imem[27] = rg(1, 2, SUBO);  imem[28] = im(XORO, 1, 8'hFF);
      imem[29] = rg(1, 1, SHL1);    imem[30] = rg(3, 1, NOTB);    imem[31] = rg(3, 3, SHR1);
      imem[32] = im(ANDO, 3, 8'hF0); imem[33] = im(ADDO, 7, 2);   imem[34] = rg(3, 7, F_ST);
      imem[35] = im(ADDO, 7, 2);    imem[36] = rg(1, 7, F_ST);    imem[37] = rg(1, 1, ZERO7);
      imem[38] = im(ADDO, 7, 2);    imem[39] = rg(1, 7, F_ST);
      imem[40] = im(PASSB, 2, 10);  imem[41] = im(PASSB, 3, 0);   imem[42] = im(ADDO, 3, 3);
      imem[43] = im(ADDO, 2, -1);   imem[44] = br(0, 2, -6);      imem[45] = im(ADDO, 7, 2);
      imem[46] = rg(3, 7, F_ST);
      imem[47] = im(ADDO, 7, 2);    imem[48] = rg(3, 7, F_ST);    imem[49] = im(ADDO, 3, 1);
      imem[50] = im(ADDO, 3, 1);    imem[51] = im(ADDO, 7, 2);    imem[52] = rg(3, 7, F_ST);
      imem[53] = im(PASSB, 4, 8'h80); imem[54] = im(SHL8, 4, 8'h80); imem[55] = br(2, 4, 2);
      imem[56] = im(ADDO, 3, 8'h40); imem[57] = br(3, 4, 2);      imem[58] = im(ADDO, 3, 1);
      imem[59] = br(1, 4, 2);       imem[60] = jp(2);             imem[61] = im(ADDO, 3, 8'h40);
      imem[62] = im(ADDO, 7, 2);    imem[63] = rg(3, 7, F_ST);    imem[64] = im(ADDO, 7, 2);
      imem[65] = rg(3, 7, F_ST);

      push(16'h0100, 16'h0004, 1, 1);  push(16'h0102, 16'h0004, 1, 1);
      push(16'h0104, 16'hA55A, 1, 1);  push(16'h0106, 16'h00A5, 1, 1);
      push(16'h0021, 16'h0034, 1, 0);  push(16'h0020, 16'h3400, 0, 1);
      push(16'h0108, 16'h3434, 1, 1);  push(16'h010A, 16'h00E0, 1, 1);
      push(16'h010C, 16'h0026, 1, 1);  push(16'h010E, 16'h0000, 1, 1);
      push(16'h0110, 16'h001E, 1, 1);  push(16'h0112, 16'h001E, 1, 1);
      push(16'h0114, 16'h0020, 1, 1);  push(16'h0116, 16'h0021, 1, 1);

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_iaddr", bus.iaddr, 16'h0000);
      check("rst_ioe", {15'b0, bus.ioe}, 16'h0001);
      check("rst_doe", {15'b0, bus.doe}, 16'h0000);
      check("rst_dwe", {14'b0, bus.dwe1, bus.dwe0}, 16'h0000);
      check("rst_daddr", bus.daddr, 16'h0000);
      check("rst_ddout", bus.ddout, 16'h0000);
      @(posedge clk); #1 rst = 1'b0;

      found = 0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk);
         if (bus.dwe0 && bus.daddr == 16'h0118 && !bus.dready) found = 1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL timeout_final_store actual=none required=store_0118");
      end else begin
         @(posedge clk); #1 rst = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check("midrst_iaddr", bus.iaddr, 16'h0000);
         check("midrst_ioe", {15'b0, bus.ioe}, 16'h0001);
         check("midrst_doe", {15'b0, bus.doe}, 16'h0000);
         check("midrst_dwe", {14'b0, bus.dwe1, bus.dwe0}, 16'h0000);
         check("midrst_daddr", bus.daddr, 16'h0000);
         check("midrst_ddout", bus.ddout, 16'h0000);
      end

`ifdef RISC16BP_BPT_EN
      gap_exp = 38;
`else
      gap_exp = 52;
`endif
      check("loop_cycles", 16'(st_cyc[8] - st_cyc[7]), 16'(gap_exp));
      check("iready_cycles", 16'(st_cyc[10] - st_cyc[9]), 16'd6);
      check("sb_drain", 16'(sb.size()), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
